// File: rtl/midi_uart_rx.sv
// MIDI IN serial receiver: 8N1 at BAUD, LSB first, one byte per frame.
// Delivers each valid byte on midi_byte with a one-clock midi_ready strobe.
// Optionally diverts System Real-Time bytes (0xF8-0xFF) to rt_byte.
// A low stop bit raises frame_err and parks the FSM in BREAK until the line
// returns high, so a held-low line cannot produce a stream of 0x00 bytes.
module midi_uart_rx #(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned BAUD      = 31250,
    parameter bit          FILTER_RT = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       midi_rx,
    output logic [7:0] midi_byte,
    output logic       midi_ready,
    output logic       frame_err,
    output logic       rt_byte
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    // Clock counter must reach CLKS_PER_BIT-1.
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         sync_q;
    logic [CNT_W-1:0]   clk_cnt_q, clk_cnt_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [7:0]         shift_q, shift_d;
    logic [7:0]         midi_byte_q, midi_byte_d;
    logic               midi_ready_q, midi_ready_d;
    logic               frame_err_q, frame_err_d;
    logic               rt_byte_q, rt_byte_d;

    logic               rx_s;
    logic               half_tick;
    logic               bit_tick;
    logic               stop_ok;
    logic               stop_bad;
    logic               is_rt;

    assign rx_s      = sync_q[1];
    assign half_tick = (clk_cnt_q == CNT_W'(HALF_BIT - 1));
    assign bit_tick  = (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign stop_ok   = (state_q == ST_STOP) && bit_tick && rx_s;
    assign stop_bad  = (state_q == ST_STOP) && bit_tick && !rx_s;
    assign is_rt     = FILTER_RT && (shift_q[7:3] == 5'b11111);

    // Two-stage synchronizer for the asynchronous line; resets to idle-high.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], midi_rx};
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and registered output flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_cnt_q    <= '0;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            midi_byte_q  <= 8'h00;
            midi_ready_q <= 1'b0;
            frame_err_q  <= 1'b0;
            rt_byte_q    <= 1'b0;
        end else begin
            clk_cnt_q    <= clk_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            midi_byte_q  <= midi_byte_d;
            midi_ready_q <= midi_ready_d;
            frame_err_q  <= frame_err_d;
            rt_byte_q    <= rt_byte_d;
        end
    end

    // Next-state logic: start detection, mid-start verification, 8 data bits, stop check.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (half_tick) begin
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_tick && (bit_cnt_q == 3'd7)) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_BREAK;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            ST_BREAK: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BREAK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Counters and shift register: bit timing and LSB-first assembly.
    always_comb begin
        clk_cnt_d = clk_cnt_q + CNT_W'(1);
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        case (state_q)
            ST_IDLE: begin
                clk_cnt_d = '0;
                bit_cnt_d = 3'd0;
            end
            ST_START: begin
                bit_cnt_d = 3'd0;
                if (half_tick) begin
                    clk_cnt_d = '0;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    shift_d   = {rx_s, shift_q[7:1]};
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (bit_tick) begin
                    clk_cnt_d = '0;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            ST_BREAK: begin
                clk_cnt_d = '0;
            end
            default: begin
                clk_cnt_d = '0;
                bit_cnt_d = 3'd0;
            end
        endcase
    end

    // Output strobes: exactly one outcome per stop sample, byte loaded with midi_ready.
    always_comb begin
        midi_ready_d = 1'b0;
        frame_err_d  = 1'b0;
        rt_byte_d    = 1'b0;
        midi_byte_d  = midi_byte_q;
        if (stop_ok) begin
            if (is_rt) begin
                rt_byte_d = 1'b1;
            end else begin
                midi_ready_d = 1'b1;
                midi_byte_d  = shift_q;
            end
        end else if (stop_bad) begin
            frame_err_d = 1'b1;
        end else begin
            midi_byte_d = midi_byte_q;
        end
    end

    assign midi_byte  = midi_byte_q;
    assign midi_ready = midi_ready_q;
    assign frame_err  = frame_err_q;
    assign rt_byte    = rt_byte_q;

endmodule
